// File: rtl/fixed_add_pkg.sv
// Shared constants and saturation-limit helpers for the fixed-point adder.
// The optional clamp is selected with the FIXED_ADD_SAT_EN macro.
package fixed_add_pkg;

    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_FRAC_BITS = 8;

    // Limits come back in the low 'width' bits of a 64-bit word.
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fixed_add_sat.sv
// Combinational overflow clamp. With FIXED_ADD_SAT_EN defined the result
// saturates in the direction of operand A's sign; otherwise it passes through.
module fixed_add_sat
    import fixed_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] wrap_sum,
    input  logic             overflow,
    input  logic             sign_a,
    output logic [WIDTH-1:0] sum
);

`ifdef FIXED_ADD_SAT_EN
    localparam logic [63:0]      MAX_FULL = sat_max(WIDTH);
    localparam logic [63:0]      MIN_FULL = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] MAX_VAL  = MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MIN_VAL  = MIN_FULL[WIDTH-1:0];

    // Overflow only happens with equal operand signs, so A's sign is the direction.
    always_comb begin
        sum = wrap_sum;
        if (overflow) begin
            sum = sign_a ? MIN_VAL : MAX_VAL;
        end
    end
`else
    logic unused_flags;

    assign unused_flags = overflow ^ sign_a;
    assign sum          = wrap_sum;
`endif

endmodule

// File: rtl/fixed_add_pipeline.sv
// Four-stage signed fixed-point adder with overflow flag; low/high halves are
// added in separate stages. Saturation is enabled by defining FIXED_ADD_SAT_EN.
module fixed_add_pipeline
    import fixed_add_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int FRAC_BITS = DEFAULT_FRAC_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    overflow
);

    localparam int HI_BITS = WIDTH - FRAC_BITS;

    // Stage 1
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    // Stage 2
    logic [FRAC_BITS-1:0] lo_sum_reg;
    logic                 carry_reg;
    logic [HI_BITS-1:0]   a_hi_reg;
    logic [HI_BITS-1:0]   b_hi_reg;
    // Stage 3
    logic [WIDTH-1:0]     wrap_reg;
    logic                 ovf_reg;
    logic                 sign_a_reg;

    logic [FRAC_BITS:0]   lo_next;
    logic [HI_BITS-1:0]   hi_next;
    logic                 ovf_next;
    logic [WIDTH-1:0]     sum_next;

    assign lo_next  = {1'b0, a_reg[FRAC_BITS-1:0]} + {1'b0, b_reg[FRAC_BITS-1:0]};
    assign hi_next  = a_hi_reg + b_hi_reg + {{(HI_BITS-1){1'b0}}, carry_reg};
    assign ovf_next = (a_hi_reg[HI_BITS-1] == b_hi_reg[HI_BITS-1]) &&
                      (hi_next[HI_BITS-1] != a_hi_reg[HI_BITS-1]);

    fixed_add_sat #(
        .WIDTH(WIDTH)
    ) u_sat (
        .wrap_sum (wrap_reg),
        .overflow (ovf_reg),
        .sign_a   (sign_a_reg),
        .sum      (sum_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            lo_sum_reg <= '0;
            carry_reg  <= 1'b0;
            a_hi_reg   <= '0;
            b_hi_reg   <= '0;
            wrap_reg   <= '0;
            ovf_reg    <= 1'b0;
            sign_a_reg <= 1'b0;
            sum        <= '0;
            overflow   <= 1'b0;
        end else begin
            a_reg      <= a;
            b_reg      <= b;

            lo_sum_reg <= lo_next[FRAC_BITS-1:0];
            carry_reg  <= lo_next[FRAC_BITS];
            a_hi_reg   <= a_reg[WIDTH-1:FRAC_BITS];
            b_hi_reg   <= b_reg[WIDTH-1:FRAC_BITS];

            wrap_reg   <= {hi_next, lo_sum_reg};
            ovf_reg    <= ovf_next;
            sign_a_reg <= a_hi_reg[HI_BITS-1];

            sum        <= sum_next;
            overflow   <= ovf_reg;
        end
    end

endmodule

// File: tb/tb_fixed_add_pipeline.sv
// Scoreboard bench for fixed_add_pipeline (default Q7.8); expected values
// follow FIXED_ADD_SAT_EN when it is defined for the build.
module tb_fixed_add_pipeline;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a   = '0;
    logic [15:0] b   = '0;
    logic [15:0] sum;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic [15:0] sum;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q[$];

`ifdef FIXED_ADD_SAT_EN
    localparam logic [15:0] POS_OVF = 16'h7FFF;
    localparam logic [15:0] NEG_OVF = 16'h8000;
    localparam logic [15:0] MIN_MIN = 16'h8000;
    localparam logic [15:0] MAX_ONE = 16'h7FFF;
`else
    localparam logic [15:0] POS_OVF = 16'h9600;
    localparam logic [15:0] NEG_OVF = 16'h6A00;
    localparam logic [15:0] MIN_MIN = 16'h0000;
    localparam logic [15:0] MAX_ONE = 16'h8000;
`endif

    fixed_add_pipeline dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .sum      (sum),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: 17-bit exact sum, then wrap or clamp.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input int due);
        logic signed [16:0] full;
        exp_t r;
        full  = $signed({x[15], x}) + $signed({y[15], y});
        r.ovf = full[16] != full[15];
        r.sum = full[15:0];
`ifdef FIXED_ADD_SAT_EN
        if (r.ovf) r.sum = full[16] ? 16'h8000 : 16'h7FFF;
`endif
        r.due = due;
        return r;
    endfunction

    task automatic test_reset();
        #1;
        compared++;
        if (sum !== 16'h0 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_initial: sum=%h overflow=%b, expected sum=0000 overflow=0", sum, overflow);
        end
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (sum !== 16'h0 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_held: sum=%h overflow=%b, expected sum=0000 overflow=0", sum, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] ta [10] = '{16'h1980, 16'hF040, 16'h1E00, 16'h6400, 16'h9C00,
                                 16'h0020, 16'h00FF, 16'h7FFF, 16'h8000, 16'h7FFF};
        logic [15:0] tb_ [10] = '{16'h0A40, 16'hF780, 16'hF3C0, 16'h3200, 16'hCE00,
                                  16'h0060, 16'h0001, 16'h8000, 16'h8000, 16'h0001};
        logic [15:0] ts [10] = '{16'h23C0, 16'hE7C0, 16'h11C0, POS_OVF, NEG_OVF,
                                 16'h0080, 16'h0100, 16'hFFFF, MIN_MIN, MAX_ONE};
        logic        to [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_t e;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i < 10) begin
                a = ta[i];
                b = tb_[i];
                q.push_back('{ts[i], to[i], cyc + 4});
            end else begin
                a = '0;
                b = '0;
            end
            @(posedge clk);
            #1;
            e = '{16'h0, 1'b0, 0};
            if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
            compared++;
            if (sum !== e.sum || overflow !== e.ovf) begin
                mismatched++;
                $display("FAIL directed[%0d]: sum=%h overflow=%b, expected sum=%h overflow=%b",
                         i, sum, overflow, e.sum, e.ovf);
            end
        end
    endtask

    task automatic test_latency();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                a = 16'h1980;
                b = 16'h0A40;
                q.push_back('{16'h23C0, 1'b0, cyc + 4});
            end else begin
                a = '0;
                b = '0;
            end
            @(posedge clk);
            #1;
            e = '{16'h0, 1'b0, 0};
            if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
            compared++;
            if (sum !== e.sum || overflow !== e.ovf) begin
                mismatched++;
                $display("FAIL latency[%0d]: sum=%h overflow=%b, expected sum=%h overflow=%b",
                         i, sum, overflow, e.sum, e.ovf);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] edges [6] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000, 16'h00FF, 16'h0001};
        exp_t e;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (i < 24) begin
                a = (i % 3 == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
                b = (i % 4 == 0) ? edges[$urandom_range(0, 5)] : 16'($urandom);
                q.push_back(model(a, b, cyc + 4));
            end else begin
                a = '0;
                b = '0;
            end
            @(posedge clk);
            #1;
            e = '{16'h0, 1'b0, 0};
            if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
            compared++;
            if (sum !== e.sum || overflow !== e.ovf) begin
                mismatched++;
                $display("FAIL back_to_back[%0d]: sum=%h overflow=%b, expected sum=%h overflow=%b",
                         i, sum, overflow, e.sum, e.ovf);
            end
        end
    endtask

    task automatic test_reset_midstream();
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a = 16'h0100;
            b = 16'h0100;
            q.push_back('{16'h0200, 1'b0, cyc + 4});
            @(posedge clk);
            #1;
            e = '{16'h0, 1'b0, 0};
            if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
            compared++;
            if (sum !== e.sum || overflow !== e.ovf) begin
                mismatched++;
                $display("FAIL pre_reset[%0d]: sum=%h overflow=%b, expected sum=%h overflow=%b",
                         i, sum, overflow, e.sum, e.ovf);
            end
        end
        // Assert reset between edges: outputs must clear with no clock edge.
        #2;
        rst = 1'b1;
        #1;
        compared++;
        if (sum !== 16'h0 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: sum=%h overflow=%b, expected sum=0000 overflow=0", sum, overflow);
        end
        q.delete();
        @(posedge clk);
        #1;
        compared++;
        if (sum !== 16'h0 || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_hold: sum=%h overflow=%b, expected sum=0000 overflow=0", sum, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0) begin
                a = 16'hF040;
                b = 16'hF780;
                q.push_back('{16'hE7C0, 1'b0, cyc + 4});
            end else begin
                a = '0;
                b = '0;
            end
            @(posedge clk);
            #1;
            e = '{16'h0, 1'b0, 0};
            if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
            compared++;
            if (sum !== e.sum || overflow !== e.ovf) begin
                mismatched++;
                $display("FAIL post_reset[%0d]: sum=%h overflow=%b, expected sum=%h overflow=%b",
                         i, sum, overflow, e.sum, e.ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_latency();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
